// File: rtl/ludm_param.sv
// ludm_param: parametrised Doolittle LU decomposition engine.
//
// Factors an N x N signed Q(W-F).F matrix in place into a unit-lower L and an
// upper U. L (strictly below the diagonal) and U (on/above it) overwrite the
// loaded matrix. Each output element takes one cycle per accumulated term plus
// one write cycle. A zero pivot aborts the run with error set.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   wr       write strobe, loads A into M[wr_addr] while not busy
//   wr_addr  write address, row*N + col
//   A        write data
//   start    one-cycle request to factor the loaded matrix
//   rd_addr  read address, row*N + col
//   L, U     registered read data (unit diagonal / zero triangles applied)
//   busy     high while factoring
//   finish   factorisation ended (success or abort), held until next wr/start
//   error    zero pivot detected, held until next wr/start
module ludm_param #(
  parameter int N  = 4,
  parameter int W  = 32,
  parameter int F  = 16,
  parameter int AW = $clog2(N * N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  A,
  input  logic          start,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  L,
  output logic [W-1:0]  U,
  output logic          busy,
  output logic          finish,
  output logic          error
);

  localparam int NN   = N * N;
  localparam int CW   = $clog2(N);
  localparam int ACCW = 2 * W + CW;   // room for N full-width products
  localparam int DW   = ACCW + 1;     // element minus scaled sum
  localparam int QW   = DW + F;       // difference pre-shifted for the divide

  localparam logic [AW-1:0]       N_A   = AW'(N);
  localparam logic [AW:0]         NN_A  = (AW + 1)'(NN);
  localparam logic [CW-1:0]       LAST  = CW'(N - 1);
  localparam logic [W-1:0]        ONE_F = {{(W - F - 1){1'b0}}, 1'b1, {F{1'b0}}};
  localparam logic signed [QW-1:0] SMAX = {{(QW - W + 1){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [QW-1:0] SMIN = {{(QW - W + 1){1'b1}}, {(W - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE, COMP, DONE} state_t;

  state_t                 state, state_n;
  logic [CW-1:0]          i, i_n;        // current row
  logic [CW-1:0]          idx, idx_n;    // U column or L row within row i
  logic [CW-1:0]          j, j_n;        // term counter
  logic                   is_l, is_l_n;  // 0: U elements of row i, 1: L elements of column i
  logic signed [ACCW-1:0] acc, acc_n;
  logic                   busy_n, finish_n, error_n;

  logic [W-1:0]  mem [NN];
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [W-1:0]  mem_wdata;

  // Datapath for the element currently being computed.
  logic [CW-1:0]          row_e, col_e;
  logic [AW-1:0]          elem_addr, a_addr, b_addr, piv_addr;
  logic [W-1:0]           a_val, b_val, cur_val, piv_val;
  logic signed [ACCW-1:0] a_x, b_x, prod, sum;
  logic signed [DW-1:0]   cur_x, sum_x, diff;
  logic signed [QW-1:0]   num, piv_x, quot, res;
  logic [W-1:0]           res_sat;

  always_comb begin
    row_e     = is_l ? idx : i;
    col_e     = is_l ? i : idx;
    elem_addr = AW'(row_e) * N_A + AW'(col_e);
    a_addr    = AW'(row_e) * N_A + AW'(j);   // L[row][j]
    b_addr    = AW'(j) * N_A + AW'(col_e);   // U[j][col]
    piv_addr  = AW'(i) * N_A + AW'(i);
    a_val     = mem[a_addr];
    b_val     = mem[b_addr];
    cur_val   = mem[elem_addr];
    piv_val   = mem[piv_addr];

    a_x  = {{(ACCW - W){a_val[W-1]}}, a_val};
    b_x  = {{(ACCW - W){b_val[W-1]}}, b_val};
    prod = a_x * b_x;

    sum   = acc >>> F;
    cur_x = {{(DW - W){cur_val[W-1]}}, cur_val};
    sum_x = {sum[ACCW-1], sum};
    diff  = cur_x - sum_x;

    // The divisor is only used once its pivot has been checked non-zero; the
    // guard just keeps the idle divider well defined.
    num   = {diff, {F{1'b0}}};
    piv_x = (piv_val == '0) ? QW'(1) : {{(QW - W){piv_val[W-1]}}, piv_val};
    quot  = num / piv_x;              // signed divide truncates toward zero
    res   = is_l ? quot : {{F{diff[DW-1]}}, diff};

    if (res > SMAX)      res_sat = SMAX[W-1:0];
    else if (res < SMIN) res_sat = SMIN[W-1:0];
    else                 res_sat = res[W-1:0];
  end

  // NOTE: every signal driven here gets a default first so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_n   = state;
    i_n       = i;
    idx_n     = idx;
    j_n       = j;
    is_l_n    = is_l;
    acc_n     = acc;
    busy_n    = busy;
    finish_n  = finish;
    error_n   = error;
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = A;

    unique case (state)
      IDLE, DONE: begin
        if (wr) begin
          // A write always wins over a simultaneous start.
          mem_we   = ({1'b0, wr_addr} < NN_A);
          finish_n = 1'b0;
          error_n  = 1'b0;
        end else if (start) begin
          finish_n = 1'b0;
          error_n  = 1'b0;
          i_n      = '0;
          idx_n    = '0;
          j_n      = '0;
          is_l_n   = 1'b0;
          acc_n    = '0;
          busy_n   = 1'b1;
          state_n  = COMP;
        end
      end

      COMP: begin
        if (j != i) begin
          acc_n = acc + prod;
          j_n   = j + CW'(1);
        end else begin
          mem_we    = 1'b1;
          mem_waddr = elem_addr;
          mem_wdata = res_sat;
          acc_n     = '0;
          j_n       = '0;
          if (!is_l && idx == i && res_sat == '0) begin
            error_n  = 1'b1;
            finish_n = 1'b1;
            busy_n   = 1'b0;
            state_n  = DONE;
          end else if (i == LAST) begin
            // Row N-1 holds only U[N-1][N-1], the final element.
            finish_n = 1'b1;
            busy_n   = 1'b0;
            state_n  = DONE;
          end else if (idx == LAST) begin
            if (!is_l) begin
              is_l_n = 1'b1;
              idx_n  = i + CW'(1);
            end else begin
              is_l_n = 1'b0;
              i_n    = i + CW'(1);
              idx_n  = i + CW'(1);
            end
          end else begin
            idx_n = idx + CW'(1);
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values of the others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      i      <= '0;
      idx    <= '0;
      j      <= '0;
      is_l   <= 1'b0;
      acc    <= '0;
      busy   <= 1'b0;
      finish <= 1'b0;
      error  <= 1'b0;
    end else begin
      state  <= state_n;
      i      <= i_n;
      idx    <= idx_n;
      j      <= j_n;
      is_l   <= is_l_n;
      acc    <= acc_n;
      busy   <= busy_n;
      finish <= finish_n;
      error  <= error_n;
    end
  end

  // NOTE: the matrix store has no reset so it maps onto plain RAM/registers
  // and survives a reset; writes are simply blocked while reset is asserted.
  always_ff @(posedge clk) begin
    if (mem_we && reset) mem[mem_waddr] <= mem_wdata;
  end

  logic [AW-1:0] rd_row, rd_col;
  assign rd_row = rd_addr / N_A;
  assign rd_col = rd_addr % N_A;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      L <= '0;
      U <= '0;
    end else if ({1'b0, rd_addr} >= NN_A) begin
      L <= '0;
      U <= '0;
    end else begin
      L <= (rd_row == rd_col) ? ONE_F : ((rd_col > rd_row) ? '0 : mem[rd_addr]);
      U <= (rd_row > rd_col) ? '0 : mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_ludm_param.sv
// Self-checking bench for ludm_param: a 2x2 instance (address widened by one
// bit so an out-of-range address is reachable) and a default 4x4 instance.
module tb_ludm_param;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr2 = 1'b0, start2 = 1'b0, wr4 = 1'b0, start4 = 1'b0;
  logic [3:0]  wa = '0, ra = '0;
  logic [31:0] a_in = '0;
  logic [31:0] l2, u2, l4, u4;
  logic        busy2, fin2, err2, busy4, fin4, err4;

  int n_checks = 0;
  int n_errors = 0;

  string       tag_q[$];
  bit          sel_q[$];
  logic [31:0] exp_l_q[$];
  logic [31:0] exp_u_q[$];

  always #5 clk = ~clk;

  ludm_param #(.N(2), .W(32), .F(16), .AW(3)) dut2 (
    .clk(clk), .reset(reset), .wr(wr2), .wr_addr(wa[2:0]), .A(a_in),
    .start(start2), .rd_addr(ra[2:0]), .L(l2), .U(u2),
    .busy(busy2), .finish(fin2), .error(err2)
  );

  ludm_param #(.N(4), .W(32), .F(16)) dut4 (
    .clk(clk), .reset(reset), .wr(wr4), .wr_addr(wa), .A(a_in),
    .start(start4), .rd_addr(ra), .L(l4), .U(u4),
    .busy(busy4), .finish(fin4), .error(err4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic wr_word(input bit sel, input int addr, input logic [31:0] d);
    @(negedge clk);
    wa   = 4'(addr);
    a_in = d;
    if (sel) wr4 = 1'b1; else wr2 = 1'b1;
    @(negedge clk);
    wr2 = 1'b0;
    wr4 = 1'b0;
  endtask

  // Pulses start, checks busy rose, then counts cycles until finish.
  // With lock set, a wr and a start are pulsed mid-run and must be ignored.
  task automatic run(input bit sel, input bit lock, output int n);
    @(negedge clk);
    if (sel) start4 = 1'b1; else start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    start4 = 1'b0;
    check("busy_rise", 32'(sel ? busy4 : busy2), 32'd1);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if ((sel ? fin4 : fin2) || n >= 200) break;
      if (lock) begin
        wa     = 4'd5;
        a_in   = 32'h0000_DEAD;
        wr4    = (n == 3);
        start4 = (n == 6);
      end
    end
    wr4    = 1'b0;
    start4 = 1'b0;
  endtask

  task automatic sb_pop();
    string t;
    logic [31:0] gl, gu;
    if (tag_q.size() == 0) return;
    t = tag_q.pop_front();
    if (sel_q.pop_front()) begin gl = l4; gu = u4; end
    else begin gl = l2; gu = u2; end
    check({t, "_L"}, gl, exp_l_q.pop_front());
    check({t, "_U"}, gu, exp_u_q.pop_front());
  endtask

  // Pipelined read: the value for an address is compared one cycle later.
  task automatic rd_issue(input bit sel, input int addr, input logic [31:0] el,
                          input logic [31:0] eu, input string tag);
    @(negedge clk);
    sb_pop();
    ra = 4'(addr);
    tag_q.push_back(tag);
    sel_q.push_back(sel);
    exp_l_q.push_back(el);
    exp_u_q.push_back(eu);
  endtask

  task automatic rd_drain();
    @(negedge clk);
    sb_pop();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  int a4 [16] = '{2, 1, 0, 1,  2, 2, 1, 1,  4, 3, 2, 4,  0, 1, 3, 7};
  int l4m[16] = '{1, 0, 0, 0,  1, 1, 0, 0,  2, 1, 1, 0,  0, 1, 2, 1};
  int u4m[16] = '{2, 1, 0, 1,  0, 1, 1, 0,  0, 0, 1, 2,  0, 0, 0, 3};

  initial begin
    int n;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst2_busy", 32'(busy2), 32'd0);
    check("rst2_fin",  32'(fin2),  32'd0);
    check("rst2_err",  32'(err2),  32'd0);
    check("rst2_L", l2, 32'd0);
    check("rst2_U", u2, 32'd0);
    check("rst4_busy", 32'(busy4), 32'd0);
    reset = 1'b1;

    // 2x2 nominal factorisation.
    wr_word(0, 0, 32'h0004_0000);
    wr_word(0, 1, 32'h0003_0000);
    wr_word(0, 2, 32'h0006_0000);
    wr_word(0, 3, 32'h0003_0000);
    run(0, 0, n);
    check("n2_cycles", 32'(n), 32'd5);
    check("n2_fin",  32'(fin2),  32'd1);
    check("n2_err",  32'(err2),  32'd0);
    check("n2_busy", 32'(busy2), 32'd0);
    rd_issue(0, 0, 32'h0001_0000, 32'h0004_0000, "n2_a0");
    rd_issue(0, 1, 32'h0000_0000, 32'h0003_0000, "n2_a1");
    rd_issue(0, 2, 32'h0001_8000, 32'h0000_0000, "n2_a2");
    rd_issue(0, 3, 32'h0001_0000, 32'hFFFE_8000, "n2_a3");
    rd_issue(0, 4, 32'h0000_0000, 32'h0000_0000, "n2_oob");
    rd_drain();
    check("n2_fin_hold", 32'(fin2), 32'd1);

    // Simultaneous wr + start while idle: only the write happens.
    @(negedge clk);
    wa = 4'd0; a_in = 32'h0001_2345; wr2 = 1'b1; start2 = 1'b1;
    @(negedge clk);
    wr2 = 1'b0; start2 = 1'b0;
    check("wrst_busy", 32'(busy2), 32'd0);
    check("wrst_fin",  32'(fin2),  32'd0);
    @(negedge clk);
    check("wrst_busy2", 32'(busy2), 32'd0);
    rd_issue(0, 0, 32'h0001_0000, 32'h0001_2345, "wrst_a0");
    rd_drain();

    // Zero pivot on the very first element.
    wr_word(0, 0, 32'h0000_0000);
    wr_word(0, 1, 32'h0001_0000);
    wr_word(0, 2, 32'h0001_0000);
    wr_word(0, 3, 32'h0000_0000);
    run(0, 0, n);
    check("zp_cycles", 32'(n), 32'd1);
    check("zp_err",  32'(err2),  32'd1);
    check("zp_busy", 32'(busy2), 32'd0);
    rd_issue(0, 0, 32'h0001_0000, 32'h0000_0000, "zp_a0");
    rd_drain();

    // Saturation of U[1][1].
    wr_word(0, 0, 32'h0001_0000);
    wr_word(0, 1, 32'(20000 * 65536));
    wr_word(0, 2, 32'h0002_0000);
    wr_word(0, 3, 32'(-30000 * 65536));
    run(0, 0, n);
    check("sat_cycles", 32'(n), 32'd5);
    check("sat_err", 32'(err2), 32'd0);
    rd_issue(0, 2, 32'h0002_0000, 32'h0000_0000, "sat_a2");
    rd_issue(0, 3, 32'h0001_0000, 32'h8000_0000, "sat_a3");
    rd_drain();

    // 4x4: reset in the middle of a run.
    for (int k = 0; k < 16; k++) wr_word(1, k, 32'(a4[k] * 65536));
    ra = 4'd0;
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_busy", 32'(busy4), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_L",    l4, 32'd0);
    check("arst_U",    u4, 32'd0);
    check("arst_busy", 32'(busy4), 32'd0);
    check("arst_fin",  32'(fin4),  32'd0);
    check("arst_err",  32'(err4),  32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Reload and run to completion with lockout pulses mid-run.
    for (int k = 0; k < 16; k++) wr_word(1, k, 32'(a4[k] * 65536));
    run(1, 1, n);
    check("n4_cycles", 32'(n), 32'd30);
    check("n4_err", 32'(err4), 32'd0);
    for (int k = 0; k < 16; k++)
      rd_issue(1, k, 32'(l4m[k] * 65536), 32'(u4m[k] * 65536), $sformatf("n4_a%0d", k));
    rd_drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
